tt_scanner: RTL and testbench
=============================

# tt_scanner

Sequential truth-table scanner that sits directly upstream of a 4-input combinational function under test (inputs x, y, w, z; output s). On a start request it drives all 16 input vectors in ascending order and samples s after a programmable settle time. It records the resulting 16-bit truth table and compares it against an expected table. It replaces hand-written exhaustive stimulus sequences with a single reusable, self-checking stage.

## Interface
- SETTLE, default 1: number of full cycles each vector is held before s is sampled. Legal range is 1..15.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a scan. Sampled only in IDLE or DONE.
- expected  input  16  expected truth table. Bit i is the expected s for vector i = {x,y,w,z}. Sampled continuously during the scan and must be held stable while busy.
- x, y, w, z  output  1 each  vector driven to the function under test. x is the MSB of the index, z is the LSB.
- s  input  1  function output, returned combinationally.
- busy  output  1  high while the scan is in progress.
- done  output  1  high from scan completion until the next accepted start or reset.
- table  output  16  captured truth table. Bit i holds s sampled for vector i.
- match  output  1  high when done=1 and table == expected.
- err_count  output  5  number of mismatching vectors, 0..16.
- first_err  output  4  index of the lowest mismatching vector. Valid only when err_count != 0; 0 otherwise.

## Operation
- Registers: state, idx[3:0], cnt[3:0], table, err_count, first_err.
- State IDLE:
  - busy=0, done=0, {x,y,w,z}=0.
  - If start=1: idx<=0, cnt<=0, table<=0, err_count<=0, first_err<=0, then go to SETTLE.
- State SETTLE:
  - busy=1 and {x,y,w,z}=idx.
  - cnt increments each cycle. When cnt==SETTLE-1, go to SAMPLE.
- State SAMPLE:
  - busy=1 and {x,y,w,z}=idx, held unchanged from SETTLE.
  - table[idx]<=s.
  - If s != expected[idx]: err_count increments; if err_count==0 before this update, first_err<=idx.
  - If idx==15, go to DONE. Otherwise idx<=idx+1, cnt<=0, and go to SETTLE.
  - idx never wraps: the transition out of idx==15 is always to DONE.
- State DONE:
  - done=1, busy=0, {x,y,w,z}={1,1,1,1} (the last vector stays held).
  - table, err_count and first_err are frozen.
  - match = (table == expected), evaluated combinationally against the live expected input.
  - If start=1: clear everything as in IDLE and go to SETTLE (back-to-back scans allowed).
- start while busy=1 is ignored; the scan is neither restarted nor extended.
- err_count reaches 16 only when every vector mismatches. It saturates naturally; there is no overflow path.
- Reset at any time, including mid-scan: next state is IDLE, and every register and output is 0 (x,y,w,z=0, busy=0, done=0, table=0, err_count=0, first_err=0, match=0). Reset overrides start in the same cycle.

## Timing
- Reset values: all outputs are 0.
- Each vector is presented for SETTLE+1 cycles: SETTLE cycles in SETTLE state plus 1 cycle in SAMPLE. s is captured at the rising edge that ends the SAMPLE cycle.
- Vector 0 appears on x,y,w,z the cycle after the edge that accepts start.
- Scan length is 16*(SETTLE+1) cycles from the accepting edge to the edge at which done rises. With SETTLE=1 this is 32 cycles.
- busy rises together with the first vector and falls on the same edge that done rises.
- done stays high until the accepting edge of the next start, then drops in the same cycle busy rises.
- The function under test is purely combinational, so SETTLE=1 is sufficient. Larger values are for wrapped or registered functions.

## Test plan
- Correct function: s = the team's 4-input SoP (minterms 1,2,4,8,10,12,14), expected=16'h5516, SETTLE=1, start pulse. Required: done after 32 cycles, table=16'h5516, match=1, err_count=0, first_err=0.
- Single fault: same function, expected=16'h5517. Required: table=16'h5516, match=0, err_count=1, first_err=0.
- Inverted function: s = ~SoP, expected=16'h5516, SETTLE=3. Required: done after 64 cycles, table=16'hAAE9, err_count=16, first_err=0.
- Sequence check: SETTLE=2, monitor {x,y,w,z}. Required: values 0..15 in order, each held exactly 3 cycles; busy high throughout; a start pulse at vector 7 has no effect.
- Mid-scan reset: assert rst during vector 9. Required: next cycle all outputs are 0 and state is IDLE. A fresh start then completes normally with table=16'h5516.
- Back-to-back scans: start in DONE with expected changed to 16'h0000. Required: done drops, a new scan runs, and it ends with err_count=7, first_err=1, match=0.

Source files
------------

// File: rtl/tt_scanner.sv
// Exhaustive truth-table scanner for a 4-input combinational function.
// Drives all 16 vectors in order, samples s after SETTLE cycles, and compares the captured table.
// The captured table is exposed as truth_table because "table" is a reserved word.
module tt_scanner #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        s,
  output logic        x,
  output logic        y,
  output logic        w,
  output logic        z,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic        match,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned TT_W  = 16;
  localparam int unsigned ERR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [IDX_W-1:0]   cnt, cnt_nxt;
  logic [TT_W-1:0]    table_nxt;
  logic [ERR_W-1:0]   err_nxt;
  logic [IDX_W-1:0]   first_nxt;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      cnt         <= '0;
      truth_table <= '0;
      err_count   <= '0;
      first_err   <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      truth_table <= table_nxt;
      err_count   <= err_nxt;
      first_err   <= first_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    table_nxt = truth_table;
    err_nxt   = err_count;
    first_nxt = first_err;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_SETTLE;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          table_nxt = '0;
          err_nxt   = '0;
          first_nxt = '0;
        end
      end
      ST_SETTLE: begin
        cnt_nxt = IDX_W'(cnt + IDX_W'(1));
        if (cnt == IDX_W'(SETTLE - 1)) begin
          state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        table_nxt[idx] = s;
        if (s != expected[idx]) begin
          err_nxt = ERR_W'(err_count + ERR_W'(1));
          // Only the first miss of the scan records its index
          if (err_count == '0) begin
            first_nxt = idx;
          end
        end
        if (idx == IDX_W'(15)) begin
          state_nxt = ST_DONE;
        end else begin
          idx_nxt   = IDX_W'(idx + IDX_W'(1));
          cnt_nxt   = '0;
          state_nxt = ST_SETTLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; DONE keeps the last vector (idx==15) on the pins
  always_comb begin
    busy         = (state == ST_SETTLE) || (state == ST_SAMPLE);
    done         = (state == ST_DONE);
    {x, y, w, z} = (state == ST_IDLE) ? IDX_W'(0) : idx;
    match        = done && (truth_table == expected);
  end

endmodule

// File: tb/tb_tt_scanner.sv
// Directed bench for tt_scanner: three instances with SETTLE=1,2,3 each driving
// its own copy of the 4-input SoP (optionally inverted) as the function under test.
module tb_tt_scanner;

  logic        clk = 1'b0;
  logic [2:0]  rst, start, inv, s;
  logic [2:0]  x, y, w, z, busy, done, match;
  logic [15:0] expected [3];
  logic [15:0] tt [3];
  logic [4:0]  ec [3];
  logic [3:0]  fe [3];
  logic [15:0] sop_tt = 16'h5516;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tt_scanner #(.SETTLE(g + 1)) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .start      (start[g]),
      .expected   (expected[g]),
      .s          (s[g]),
      .x          (x[g]),
      .y          (y[g]),
      .w          (w[g]),
      .z          (z[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .truth_table(tt[g]),
      .match      (match[g]),
      .err_count  (ec[g]),
      .first_err  (fe[g])
    );
    // SoP with minterms 1,2,4,8,10,12,14, optionally inverted
    assign s[g] = sop_tt[{x[g], y[g], w[g], z[g]}] ^ inv[g];
  end

  typedef struct {
    int          k;
    logic        inv;
    logic [15:0] exp_in;
    logic [15:0] tt;
    logic [4:0]  ec;
    logic [3:0]  fe;
    logic        m;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [3:0] vec_of(input int k);
    return {x[k], y[k], w[k], z[k]};
  endfunction

  // Pulse start at a negedge; return the number of edges from acceptance to done
  task automatic run_scan(input int k, output int n);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    n = 0;
    while (!done[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic chk_zero(input string tag, input int k);
    chk({tag, " vec"},   32'(vec_of(k)), 32'd0);
    chk({tag, " busy"},  32'(busy[k]),   32'd0);
    chk({tag, " done"},  32'(done[k]),   32'd0);
    chk({tag, " table"}, 32'(tt[k]),     32'd0);
    chk({tag, " err"},   32'(ec[k]),     32'd0);
    chk({tag, " first"}, 32'(fe[k]),     32'd0);
    chk({tag, " match"}, 32'(match[k]),  32'd0);
  endtask

  initial begin
    int n;
    rst   = 3'b111;
    start = 3'b000;
    inv   = 3'b000;
    for (int k = 0; k < 3; k++) expected[k] = 16'h0000;

    vt[0] = '{k: 0, inv: 1'b0, exp_in: 16'h5516, tt: 16'h5516, ec: 5'd0,  fe: 4'd0, m: 1'b1};
    vt[1] = '{k: 0, inv: 1'b0, exp_in: 16'h5517, tt: 16'h5516, ec: 5'd1,  fe: 4'd0, m: 1'b0};
    vt[2] = '{k: 2, inv: 1'b1, exp_in: 16'h5516, tt: 16'hAAE9, ec: 5'd16, fe: 4'd0, m: 1'b0};
    vt[3] = '{k: 1, inv: 1'b0, exp_in: 16'h5516, tt: 16'h5516, ec: 5'd0,  fe: 4'd0, m: 1'b1};
    vt[4] = '{k: 0, inv: 1'b1, exp_in: 16'hAAE9, tt: 16'hAAE9, ec: 5'd0,  fe: 4'd0, m: 1'b1};

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) chk_zero($sformatf("reset%0d", k), k);
    rst = 3'b000;
    @(negedge clk);

    // Table-driven full scans
    for (int i = 0; i < 5; i++) begin
      int k;
      k           = vt[i].k;
      inv[k]      = vt[i].inv;
      expected[k] = vt[i].exp_in;
      run_scan(k, n);
      chk($sformatf("v%0d cycles", i), 32'(n),        32'(16 * (k + 2)));
      chk($sformatf("v%0d busy", i),   32'(busy[k]),  32'd0);
      chk($sformatf("v%0d vec", i),    32'(vec_of(k)), 32'hF);
      chk($sformatf("v%0d table", i),  32'(tt[k]),    32'(vt[i].tt));
      chk($sformatf("v%0d err", i),    32'(ec[k]),    32'(vt[i].ec));
      chk($sformatf("v%0d first", i),  32'(fe[k]),    32'(vt[i].fe));
      chk($sformatf("v%0d match", i),  32'(match[k]), 32'(vt[i].m));
    end

    // match follows the live expected input while done; the table stays frozen
    expected[0] = 16'h1234;
    @(negedge clk);
    chk("live match low", 32'(match[0]), 32'd0);
    chk("frozen table",   32'(tt[0]),    32'hAAE9);

    // Back-to-back scan from DONE with a new expected table
    inv[0]      = 1'b0;
    expected[0] = 16'h0000;
    start[0]    = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("b2b done drop", 32'(done[0]), 32'd0);
    chk("b2b busy rise", 32'(busy[0]), 32'd1);
    chk("b2b cleared",   32'(ec[0]),   32'd0);
    n = 0;
    while (!done[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b2b cycles", 32'(n),        32'd32);
    chk("b2b err",    32'(ec[0]),    32'd7);
    chk("b2b first",  32'(fe[0]),    32'd1);
    chk("b2b match",  32'(match[0]), 32'd0);
    chk("b2b table",  32'(tt[0]),    32'h5516);

    // Sequence check on SETTLE=2: each vector held 3 cycles, start during vector 7 ignored
    inv[1]      = 1'b0;
    expected[1] = 16'h5516;
    start[1]    = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    for (int c = 0; c < 48; c++) begin
      chk($sformatf("seq vec c%0d", c),  32'(vec_of(1)), 32'(c / 3));
      chk($sformatf("seq busy c%0d", c), 32'(busy[1]),   32'd1);
      start[1] = (c == 22);
      @(negedge clk);
    end
    start[1] = 1'b0;
    chk("seq done",  32'(done[1]),  32'd1);
    chk("seq busy",  32'(busy[1]),  32'd0);
    chk("seq table", 32'(tt[1]),    32'h5516);
    chk("seq match", 32'(match[1]), 32'd1);
    @(negedge clk);
    chk("seq no restart", 32'(busy[1]), 32'd0);

    // Mid-scan reset during vector 9 on SETTLE=3, then a fresh scan
    inv[2]      = 1'b0;
    expected[2] = 16'h5516;
    start[2]    = 1'b1;
    @(negedge clk);
    start[2] = 1'b0;
    repeat (37) @(negedge clk);
    chk("pre-reset vec", 32'(vec_of(2)), 32'd9);
    rst[2]   = 1'b1;
    start[2] = 1'b1;
    @(negedge clk);
    rst[2]   = 1'b0;
    start[2] = 1'b0;
    chk_zero("midrst", 2);
    @(negedge clk);
    chk("midrst idle", 32'(busy[2]), 32'd0);
    run_scan(2, n);
    chk("rescan cycles", 32'(n),        32'd64);
    chk("rescan table",  32'(tt[2]),    32'h5516);
    chk("rescan err",    32'(ec[2]),    32'd0);
    chk("rescan match",  32'(match[2]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
